div_iter: RTL and testbench

Iterative radix-2 restoring divider: the responder side of the execute stage's `valid`/`data_ok` multicycle handshake. It serves signed and unsigned DIV/REM in both 64-bit and 32-bit word form, delivering quotient and remainder together. The unit sits beside the ALU in the execute stage. While the ALU holds `valid`, it stalls the pipeline until `data_ok` rises.

---
 rtl/div_iter.sv | 188 ++++++++++++++++++
 tb/tb_div_iter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider: signed/unsigned DIV/REM, 64-bit and 32-bit word forms. Optional `DIV_ZERO_BYPASS_EN.
// Latency: data_ok rises N+2 cycles after the accept edge (N = 64, or 32 in word mode); 2 cycles for special cases with bypass.
// Backpressure: requester holds valid until data_ok; dropping valid mid-calculation aborts, dropping it in DONE releases the result.
module div_iter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            valid,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            is_signed,
    input  logic            word,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem,
    output logic            data_ok,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state;
    logic [6:0]      cnt;
    logic [XLEN-1:0] tag_a;
    logic [XLEN-1:0] tag_b;
    logic            tag_signed;
    logic            tag_word;
    logic [XLEN-1:0] rem_w;
    logic [XLEN-1:0] q_w;
    logic [XLEN-1:0] dvs;
    logic            neg_q;
    logic            neg_r;
    logic            spec_dz;
    logic            spec_ov;

    // Request decode: operand signs, magnitudes and special-case detection
    logic            sa;
    logic            sb;
    logic [XLEN-1:0] a_neg;
    logic [XLEN-1:0] b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN-1:0] dvd_load;
    logic            b_zero;
    logic            ovf;
    logic            req_match;
    logic            accept;

    // Decode the incoming request; word-mode dividend is parked in the top half so 32 shifts consume it
    always_comb begin
        sa       = is_signed & (word ? a[31] : a[XLEN-1]);
        sb       = is_signed & (word ? b[31] : b[XLEN-1]);
        a_neg    = -a;
        b_neg    = -b;
        abs_a    = word ? {32'b0, (sa ? a_neg[31:0] : a[31:0])} : (sa ? a_neg : a);
        abs_b    = word ? {32'b0, (sb ? b_neg[31:0] : b[31:0])} : (sb ? b_neg : b);
        dvd_load = word ? {abs_a[31:0], 32'b0} : abs_a;
        b_zero   = word ? (b[31:0] == 32'b0) : (b == '0);
        ovf      = is_signed & (word ? ((a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF))
                                     : ((a == 64'h8000_0000_0000_0000) && (b == {XLEN{1'b1}})));
        req_match = (a == tag_a) && (b == tag_b) && (is_signed == tag_signed) && (word == tag_word);
        accept    = valid && ((state == IDLE) || ((state == DONE) && !req_match));
    end

    // One restoring step: shift {rem, quot} left, trial-subtract the divisor
    logic [XLEN:0]   shifted;
    logic            trial_neg;
    logic [XLEN-1:0] trial_sub;

    // Trial subtraction; a negative result keeps the shifted remainder
    always_comb begin
        shifted   = {rem_w, q_w[XLEN-1]};
        trial_neg = shifted < {1'b0, dvs};
        trial_sub = shifted[XLEN-1:0] - dvs;
    end

    // Sign fix-up and special-result substitution applied in FIX
    logic [XLEN-1:0] q_raw;
    logic [XLEN-1:0] q_sgn;
    logic [XLEN-1:0] r_sgn;
    logic [XLEN-1:0] a_sx;
    logic [XLEN-1:0] q_fin;
    logic [XLEN-1:0] r_fin;

    // Build final quotient/remainder from the magnitudes and recorded signs
    always_comb begin
        q_raw = tag_word ? {32'b0, q_w[31:0]} : q_w;
        q_sgn = neg_q ? -q_raw : q_raw;
        r_sgn = neg_r ? -rem_w : rem_w;
        a_sx  = tag_word ? {{32{tag_a[31]}}, tag_a[31:0]} : tag_a;
        if (spec_dz) begin
            q_fin = {XLEN{1'b1}};
            r_fin = a_sx;
        end else if (spec_ov) begin
            q_fin = a_sx;
            r_fin = '0;
        end else if (tag_word) begin
            q_fin = {{32{q_sgn[31]}}, q_sgn[31:0]};
            r_fin = {{32{r_sgn[31]}}, r_sgn[31:0]};
        end else begin
            q_fin = q_sgn;
            r_fin = r_sgn;
        end
    end

    // Control FSM with datapath registers; accept is shared by IDLE and back-to-back DONE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            cnt        <= '0;
            tag_a      <= '0;
            tag_b      <= '0;
            tag_signed <= 1'b0;
            tag_word   <= 1'b0;
            rem_w      <= '0;
            q_w        <= '0;
            dvs        <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            spec_dz    <= 1'b0;
            spec_ov    <= 1'b0;
            quot       <= '0;
            rem        <= '0;
            data_ok    <= 1'b0;
            busy       <= 1'b0;
        end else if (accept) begin
            tag_a      <= a;
            tag_b      <= b;
            tag_signed <= is_signed;
            tag_word   <= word;
            rem_w      <= '0;
            q_w        <= dvd_load;
            dvs        <= abs_b;
            neg_q      <= sa ^ sb;
            neg_r      <= sa;
            spec_dz    <= b_zero;
            spec_ov    <= ovf;
            cnt        <= word ? 7'd32 : 7'd64;
            data_ok    <= 1'b0;
            busy       <= 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
            state      <= (b_zero || ovf) ? FIX : CALC;
`else
            state      <= CALC;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                CALC: begin
                    if (!valid) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        rem_w <= trial_neg ? shifted[XLEN-1:0] : trial_sub;
                        q_w   <= {q_w[XLEN-2:0], ~trial_neg};
                        cnt   <= cnt - 7'd1;
                        if (cnt == 7'd1) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    busy <= 1'b0;
                    if (!valid) begin
                        state <= IDLE;
                    end else begin
                        quot    <= q_fin;
                        rem     <= r_fin;
                        data_ok <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (!valid) begin
                        data_ok <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: table of directed divides plus back-to-back, abort and reset sequences.
// Latency is counted with the cycle after the accept edge as cycle 1.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
module tb_div_iter;

    logic        clk;
    logic        resetn;
    logic        valid;
    logic [63:0] a;
    logic [63:0] b;
    logic        is_signed;
    logic        word;
    logic [63:0] quot;
    logic [63:0] rem;
    logic        data_ok;
    logic        busy;

    int checks;
    int failures;

`ifdef DIV_ZERO_BYPASS_EN
    localparam int LS64 = 2;
    localparam int LS32 = 2;
`else
    localparam int LS64 = 66;
    localparam int LS32 = 34;
`endif

    div_iter #(.XLEN(64)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .valid    (valid),
        .a        (a),
        .b        (b),
        .is_signed(is_signed),
        .word     (word),
        .quot     (quot),
        .rem      (rem),
        .data_ok  (data_ok),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        s;
        logic        w;
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Present a request and wait (bounded) for data_ok; cyc=1 is the cycle after the accept edge
    task automatic do_req(input logic [63:0] ai, input logic [63:0] bi, input logic si, input logic wi,
                          output int cyc, output logic busy1, output logic dok1);
        a         = ai;
        b         = bi;
        is_signed = si;
        word      = wi;
        valid     = 1'b1;
        @(posedge clk);
        #1;
        cyc   = 1;
        busy1 = busy;
        dok1  = data_ok;
        while (!data_ok && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    int   cyc;
    logic busy1;
    logic dok1;

    initial begin
        checks   = 0;
        failures = 0;

        vt[0]  = '{64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 66};
        vt[1]  = '{64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 34};
        vt[2]  = '{64'h1234, 64'd0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, LS64};
        vt[3]  = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'd0, LS64};
        vt[4]  = '{64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 66};
        vt[5]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 66};
        vt[6]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1'b0, 1'b1, 64'h0000_0000_0FFF_FFFF, 64'hF, 34};
        vt[7]  = '{64'h0000_0000_8000_0000, 64'h0000_0001_0000_0000, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, LS32};
        vt[8]  = '{64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd0, LS32};
        vt[9]  = '{64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 66};
        vt[10] = '{64'h0000_0000_FFFF_FFFE, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 34};

        resetn    = 1'b0;
        valid     = 1'b0;
        a         = '0;
        b         = '0;
        is_signed = 1'b0;
        word      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_quot", quot, 64'd0);
        chk("reset_rem", rem, 64'd0);
        chk("reset_data_ok", {63'd0, data_ok}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven divides
        for (int i = 0; i < 11; i++) begin
            do_req(vt[i].a, vt[i].b, vt[i].s, vt[i].w, cyc, busy1, dok1);
            chk($sformatf("v%0d_busy_after_accept", i), {63'd0, busy1}, 64'd1);
            chk($sformatf("v%0d_latency", i), 64'(cyc), 64'(vt[i].lat));
            chk($sformatf("v%0d_quot", i), quot, vt[i].q);
            chk($sformatf("v%0d_rem", i), rem, vt[i].r);
            chk($sformatf("v%0d_busy_done", i), {63'd0, busy}, 64'd0);
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("v%0d_hold_data_ok", i), {63'd0, data_ok}, 64'd1);
            chk($sformatf("v%0d_hold_quot", i), quot, vt[i].q);
            valid = 1'b0;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_data_ok_drop", i), {63'd0, data_ok}, 64'd0);
        end

        // Back-to-back: new request while DONE and valid stays high
        do_req(64'd100, 64'd7, 1'b0, 1'b0, cyc, busy1, dok1);
        chk("b2b_first_quot", quot, 64'd14);
        do_req(64'd50, 64'd5, 1'b0, 1'b0, cyc, busy1, dok1);
        chk("b2b_data_ok_drop", {63'd0, dok1}, 64'd0);
        chk("b2b_latency", 64'(cyc), 64'd66);
        chk("b2b_quot", quot, 64'd10);
        chk("b2b_rem", rem, 64'd0);
        valid = 1'b0;
        @(posedge clk);
        #1;

        // Abort: drop valid at CALC cycle 10, results keep the previous divide
        do_req(64'd100, 64'd7, 1'b0, 1'b0, cyc, busy1, dok1);
        valid = 1'b0;
        @(posedge clk);
        #1;
        a     = 64'd50;
        b     = 64'd5;
        valid = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1;
        chk("abort_busy_in_calc", {63'd0, busy}, 64'd1);
        valid = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_data_ok", {63'd0, data_ok}, 64'd0);
        chk("abort_quot", quot, 64'd14);
        chk("abort_rem", rem, 64'd2);
        repeat (70) @(posedge clk);
        #1;
        chk("abort_quot_later", quot, 64'd14);
        chk("abort_data_ok_later", {63'd0, data_ok}, 64'd0);

        // Reset asserted mid-CALC clears outputs without a clock edge
        a     = 64'd1000;
        b     = 64'd3;
        valid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("rst_quot", quot, 64'd0);
        chk("rst_rem", rem, 64'd0);
        chk("rst_data_ok", {63'd0, data_ok}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        valid = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_idle_busy", {63'd0, busy}, 64'd0);
        chk("rst_idle_data_ok", {63'd0, data_ok}, 64'd0);
        do_req(64'd1000, 64'd3, 1'b0, 1'b0, cyc, busy1, dok1);
        chk("rst_recover_latency", 64'(cyc), 64'd66);
        chk("rst_recover_quot", quot, 64'd333);
        chk("rst_recover_rem", rem, 64'd1);
        valid = 1'b0;
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
